serial_tx_buffered: RTL and testbench
=====================================

Name: serial_tx_buffered

Overview:
Parametrised successor to the fixed 8N1 serial transmitter. It adds a small transmit FIFO so callers can queue characters without waiting on busy. Data width, stop-bit count, baud divisor and FIFO depth are configurable, and a parity bit can be compiled in. It sits between character-generating logic (e.g. the fizzbuzz sequencer) and the board UART TX pin.

Parameters:
CLK_DIV, 434, clocks per serial bit (50 MHz / 115200); must be >= 2.
DATA_BITS, 8, data bits per frame, 5..9.
STOP_BITS, 1, stop bits per frame, 1 or 2.
FIFO_DEPTH, 4, FIFO entries; power of two, >= 2.
ODD_PARITY, 0, 0 = even parity, 1 = odd parity; used only when SERIAL_TX_PARITY_EN is defined.

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous active-low reset; 0 = reset
char  input  DATA_BITS  character to queue
send  input  1  1-cycle write strobe; char is sampled when send=1 and full=0
full  output  1  FIFO holds FIFO_DEPTH entries
level  output  $clog2(FIFO_DEPTH)+1  number of queued characters, excluding the frame in flight
out  output  1  serial line, idle high
busy  output  1  frame in flight or level != 0

Behaviour:
- Reset (rst=0 at an edge): out=1, busy=0, full=0, level=0, FSM=IDLE, divider=0, FIFO pointers=0.
- Reset mid-frame aborts the frame. out=1 from the next edge. Queued data is discarded.
- Push: when send=1 and full=0, char is written and level increments.
- send=1 while full=1 is ignored. The character is dropped with no other side effect, and full/level are unchanged.
- Pop: occurs in the cycle the FSM leaves IDLE or STOP for START.
- Simultaneous push and pop leaves level unchanged. full is the registered value (level==FIFO_DEPTH), so a push in the pop cycle while full is still dropped.
- FSM states: IDLE, START, DATA, PARITY (macro only), STOP.
  - IDLE -> START when level != 0.
  - START -> DATA after CLK_DIV clocks.
  - DATA -> PARITY/STOP after DATA_BITS bits.
  - PARITY -> STOP after CLK_DIV clocks.
  - STOP -> START if level != 0 after STOP_BITS*CLK_DIV clocks, otherwise -> IDLE.
- Bit timing: every bit is exactly CLK_DIV clocks. Data is shifted out LSB first from a shift register loaded at pop.
- Line levels: out=0 in START, data bit value in DATA, computed bit in PARITY, 1 in STOP and IDLE. out is registered and glitch-free.
- Latency: send sampled at edge N with FSM idle and FIFO empty -> out falls at edge N+2.
- Back-to-back frames have zero idle clocks between the last stop bit and the next start bit.
- Frame length is (1 + DATA_BITS + P + STOP_BITS) * CLK_DIV clocks, where P = 1 with the macro, else 0.
- busy is combinational from registered state: (FSM != IDLE) || (level != 0). It rises the cycle after an accepted push into an idle block, and falls on the cycle the FSM returns to IDLE with the FIFO empty.
- FIFO pointers wrap modulo FIFO_DEPTH. level never exceeds FIFO_DEPTH and never underflows.

Optional Feature:
- Macro SERIAL_TX_PARITY_EN.
- Defined: a PARITY state is inserted after DATA.
  - Parity bit = XOR of the data bits when ODD_PARITY=0.
  - Parity bit = XNOR of the data bits when ODD_PARITY=1.
  - Frame gains one bit time.
- Undefined: no PARITY state and no parity logic. ODD_PARITY is ignored and the frame is 1+DATA_BITS+STOP_BITS bits.

Test Plan:
- Reset: hold rst=0 for 2 edges -> out=1, busy=0, full=0, level=0. Then release with send=0 -> all outputs stay unchanged for 100 clocks.
- Single char (CLK_DIV=4, 8N1): push 0x42 -> out falls 2 edges later. Then out = 0,0,1,0,0,0,0,1,0,1, each bit held 4 clocks; busy falls after 40 clocks of frame.
- Back-to-back: push 0x55 then 0xAA on consecutive cycles -> two contiguous 40-clock frames with no idle gap. level goes 1 -> 1 -> 0 at the pops; busy stays high throughout.
- Overflow (FIFO_DEPTH=4): during a frame, push 0x31..0x35 on 5 consecutive cycles -> level reaches 4 and full=1, 0x35 is dropped. Line carries 0x31..0x34 in order.
- Parity (macro defined, ODD_PARITY=0): push 0x42 -> parity bit 0 appears between bit7 and stop, giving 44 clocks. With ODD_PARITY=1 -> parity bit 1. With the macro undefined -> 40-clock frame.
- Reset mid-frame: rst=0 for one edge during data bit 3 with 2 chars queued -> out=1 and level=0 next edge, busy=0, and no further start bits appear.

Source files
------------

// File: rtl/serial_tx_buffered.sv
// rtl/serial_tx_buffered.sv - buffered serial transmitter with FIFO; parity frame bit via SERIAL_TX_PARITY_EN
module serial_tx_buffered #(
    parameter int CLK_DIV    = 434,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int ODD_PARITY = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_BITS-1:0]          char,
    input  logic                          send,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          out,
    output logic                          busy
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam int DW = $clog2(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic [LW-1:0] DEPTH_L   = LW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef SERIAL_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t state, state_n;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr, rd_ptr;
    logic [DATA_BITS-1:0] shreg;
    logic [DW-1:0]        div_cnt;
    logic [3:0]           bit_cnt;
    logic                 tick;
    logic                 push, pop;
`ifdef SERIAL_TX_PARITY_EN
    logic                 par;
`endif

    assign full = (level == DEPTH_L);
    assign busy = (state != S_IDLE) || (level != '0);
    assign push = send && !full;
    assign tick = (div_cnt == DIV_LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // A pop is the load of the next frame; it only happens on the way into START.
    always_comb begin
        state_n = state;
        pop     = 1'b0;
        case (state)
            S_IDLE: begin
                if (level != '0) begin
                    state_n = S_START;
                    pop     = 1'b1;
                end
            end
            S_START: begin
                if (tick) state_n = S_DATA;
            end
            S_DATA: begin
                if (tick && bit_cnt == DATA_LAST) begin
`ifdef SERIAL_TX_PARITY_EN
                    state_n = S_PARITY;
`else
                    state_n = S_STOP;
`endif
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            S_PARITY: begin
                if (tick) state_n = S_STOP;
            end
`endif
            S_STOP: begin
                if (tick && bit_cnt == STOP_LAST) begin
                    if (level != '0) begin
                        state_n = S_START;
                        pop     = 1'b1;
                    end else begin
                        state_n = S_IDLE;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= char;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            div_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            out     <= 1'b1;
`ifdef SERIAL_TX_PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                shreg  <= mem[rd_ptr];
`ifdef SERIAL_TX_PARITY_EN
                par    <= (^mem[rd_ptr]) ^ (ODD_PARITY != 0);
`endif
            end

            if (push && !pop)      level <= level + 1'b1;
            else if (!push && pop) level <= level - 1'b1;

            if (state == S_IDLE || tick) div_cnt <= '0;
            else                         div_cnt <= div_cnt + 1'b1;

            if (tick) begin
                if (state_n != state) bit_cnt <= '0;
                else                  bit_cnt <= bit_cnt + 1'b1;
                if (state == S_DATA) shreg <= shreg >> 1;
            end

            // Line follows the state one clock later, so every level is held a full bit time.
            case (state)
                S_START:  out <= 1'b0;
                S_DATA:   out <= shreg[0];
`ifdef SERIAL_TX_PARITY_EN
                S_PARITY: out <= par;
`endif
                default:  out <= 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_tx_buffered.sv
// tb/tb_serial_tx_buffered.sv - randomized bench against a frame-schedule model of serial_tx_buffered
module tb_serial_tx_buffered;

    localparam int CLK_DIV    = 4;
    localparam int DATA_BITS  = 8;
    localparam int STOP_BITS  = 1;
    localparam int FIFO_DEPTH = 4;
    localparam int ODD_PARITY = 0;
`ifdef SERIAL_TX_PARITY_EN
    localparam int PBITS = 1;
`else
    localparam int PBITS = 0;
`endif
    localparam int FRAME_BITS = 1 + DATA_BITS + PBITS + STOP_BITS;
    localparam int FRAME_CLKS = FRAME_BITS * CLK_DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] ch = 8'h00;
    logic       send = 1'b0;
    logic       full;
    logic [2:0] level;
    logic       out;
    logic       busy;

    int checks = 0;
    int errors = 0;

    // Model: accepted characters with their acceptance edge, plus the active frame window.
    int         q_t[$];
    logic [7:0] q_c[$];
    int         cyc = 0;
    int         cur_s = -1000;
    int         cur_end = -1000;
    logic [15:0] fb = '1;

    serial_tx_buffered #(
        .CLK_DIV(CLK_DIV), .DATA_BITS(DATA_BITS), .STOP_BITS(STOP_BITS),
        .FIFO_DEPTH(FIFO_DEPTH), .ODD_PARITY(ODD_PARITY)
    ) dut (
        .clk(clk), .rst(rst), .char(ch), .send(send),
        .full(full), .level(level), .out(out), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step(input logic s, input logic [7:0] c, input logic r);
        logic e_out;
        logic acc;
        int   pre;
        send = s;
        ch   = c;
        rst  = r;
        @(posedge clk);
        cyc++;
        if (cyc - 1 >= cur_s && cyc - 1 < cur_end) e_out = fb[(cyc - 1 - cur_s) / CLK_DIV];
        else                                         e_out = 1'b1;
        if (!r) begin
            q_t.delete();
            q_c.delete();
            cur_s   = -1000;
            cur_end = -1000;
            e_out   = 1'b1;
        end else begin
            pre = q_t.size();
            acc = s && (pre < FIFO_DEPTH);
            if (pre > 0 && q_t[0] < cyc && cyc >= cur_end) begin
                fb = '1;
                fb[0] = 1'b0;
                for (int i = 0; i < DATA_BITS; i++) fb[1 + i] = q_c[0][i];
                if (PBITS == 1) fb[1 + DATA_BITS] = (^q_c[0]) ^ (ODD_PARITY != 0);
                void'(q_t.pop_front());
                void'(q_c.pop_front());
                cur_s   = cyc;
                cur_end = cyc + FRAME_CLKS;
            end
            if (acc) begin
                q_t.push_back(cyc);
                q_c.push_back(c);
            end
        end
        #1;
        check("out",   {31'd0, out},   {31'd0, e_out});
        check("level", {29'd0, level}, q_t.size());
        check("full",  {31'd0, full},  {31'd0, q_t.size() == FIFO_DEPTH});
        check("busy",  {31'd0, busy},  {31'd0, (q_t.size() != 0) || (cyc < cur_end)});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b1);
    endtask

    initial begin
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        idle(100);

        step(1'b1, 8'h42, 1'b1);
        idle(50);

        step(1'b1, 8'h55, 1'b1);
        step(1'b1, 8'hAA, 1'b1);
        idle(90);

        step(1'b1, 8'h20, 1'b1);
        idle(8);
        for (int i = 0; i < 5; i++) step(1'b1, 8'h31 + 8'(i), 1'b1);
        idle(260);

        step(1'b1, 8'h5A, 1'b1);
        step(1'b1, 8'hC3, 1'b1);
        step(1'b1, 8'h0F, 1'b1);
        idle(16);
        step(1'b0, 8'h00, 1'b0);
        idle(80);

        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 1499) == 0) step(1'b0, 8'h00, 1'b0);
            else step($urandom_range(0, 2) == 0, 8'($urandom), 1'b1);
        end
        for (int i = 0; i < 8; i++) step(1'b1, 8'($urandom), 1'b1);
        idle(FRAME_CLKS * (FIFO_DEPTH + 2));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
